// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bus bundle between the IF/DM requesters, the arbiter and the
//               unified single-port memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_done;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_done;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requester / memory side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Serialises fetch and load/store accesses onto one single-port
//               memory with fixed read latency; data-priority or round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MEM_LAT   = 1,
    parameter int DATA_PRIO = 1
) (
    input  wire logic          clk1,
    input  wire logic          rst,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ACCESS   = 2'd1;
    localparam logic [1:0] c_WAIT     = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;
    localparam logic [1:0] c_CNT_INIT = 2'(MEM_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          last_dm_q, last_dm_d;
    logic          owner_dm_q, owner_dm_d;
    logic          is_write_q, is_write_d;
    logic          if_gnt_q, if_gnt_d;
    logic          dm_gnt_q, dm_gnt_d;
    logic          if_done_q, if_done_d;
    logic          dm_done_q, dm_done_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;

    logic w_arb;
    logic w_start;
    logic w_pick_dm;
    logic w_cap;

    // Arbitration happens in IDLE and again in DONE for back-to-back accesses
    assign w_arb     = (state_q == c_IDLE) || (state_q == c_DONE);
    assign w_start   = w_arb && (bus.if_req || bus.dm_req);
    assign w_pick_dm = (DATA_PRIO != 0)               ? bus.dm_req :
                       (bus.dm_req && bus.if_req)     ? !last_dm_q :
                                                        bus.dm_req;
    assign w_cap     = (state_q == c_WAIT) && (cnt_q == 2'd0);

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= c_IDLE;
            cnt_q       <= 2'd0;
            last_dm_q   <= 1'b0;
            owner_dm_q  <= 1'b0;
            is_write_q  <= 1'b0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dm_q   <= last_dm_d;
            owner_dm_q  <= owner_dm_d;
            is_write_q  <= is_write_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE,
            c_DONE:   state_d = w_start ? c_ACCESS : c_IDLE;
            c_ACCESS: state_d = c_WAIT;
            c_WAIT:   state_d = w_cap ? c_DONE : c_WAIT;
            default:  state_d = c_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        last_dm_d   = last_dm_q;
        owner_dm_d  = owner_dm_q;
        is_write_d  = is_write_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        if (w_start) begin
            if_gnt_d    = !w_pick_dm;
            dm_gnt_d    = w_pick_dm;
            mem_en_d    = 1'b1;
            mem_we_d    = w_pick_dm && bus.dm_we;
            mem_addr_d  = w_pick_dm ? bus.dm_addr : bus.if_addr;
            mem_wdata_d = w_pick_dm ? bus.dm_wdata : '0;
            last_dm_d   = w_pick_dm;
            owner_dm_d  = w_pick_dm;
            is_write_d  = w_pick_dm && bus.dm_we;
        end

        if (state_q == c_ACCESS) begin
            cnt_d = c_CNT_INIT;
        end

        if (state_q == c_WAIT) begin
            if (cnt_q != 2'd0) begin
                cnt_d = cnt_q - 2'd1;
            end else begin
                if_done_d = !owner_dm_q;
                dm_done_d = owner_dm_q;
                if (!is_write_q) begin
                    if (owner_dm_q) dm_rdata_d = bus.mem_rdata;
                    else            if_rdata_d = bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.dm_gnt    = dm_gnt_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Randomised bench for mem_port_arbiter against a transaction
//               level timing model; two configurations run side by side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int NCYC = 3000;

    logic clk1;
    int   n_checks;
    int   n_pass;

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic chk(input int cfg, input string tag,
                       input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, tag, got, exp, $time);
        else
            n_pass++;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int LAT  = (g == 0) ? 1 : 3;
        localparam int PRIO = (g == 0) ? 1 : 0;

        mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
        logic rst;

        mem_port_arbiter #(
            .AW(32), .DW(32), .MEM_LAT(LAT), .DATA_PRIO(PRIO)
        ) u_dut (
            .clk1 (clk1),
            .rst  (rst),
            .bus  (bus)
        );

        // Model: one outstanding transaction described by its gnt/done cycles
        int          t_gnt, t_done, arb_ok, if_gc, dm_gc;
        bit          own_dm, own_we, last_dm, forced, prev_rst, r, pd, fin;
        logic [31:0] own_addr, own_wdata, cap, ex_if, ex_dm;

        initial begin
            fin           = 1'b0;
            rst           = 1'b1;
            bus.if_req    = 1'b0;
            bus.if_addr   = '0;
            bus.dm_req    = 1'b0;
            bus.dm_we     = 1'b0;
            bus.dm_addr   = '0;
            bus.dm_wdata  = '0;
            bus.mem_rdata = '0;
            t_gnt = -100; t_done = -100; arb_ok = 0; if_gc = -100; dm_gc = -100;
            own_dm = 0; own_we = 0; last_dm = 0; forced = 0; prev_rst = 0;
            own_addr = '0; own_wdata = '0; cap = '0; ex_if = '0; ex_dm = '0;

            for (int c = 0; c < NCYC; c++) begin
                @(posedge clk1);
                #1;
                if (c == t_done && !own_we) begin
                    if (own_dm) ex_dm = cap;
                    else        ex_if = cap;
                end
                if (c >= 1) begin
                    chk(g, "if_gnt",   {31'd0, bus.if_gnt},  {31'd0, c == t_gnt && !own_dm});
                    chk(g, "dm_gnt",   {31'd0, bus.dm_gnt},  {31'd0, c == t_gnt && own_dm});
                    chk(g, "if_done",  {31'd0, bus.if_done}, {31'd0, c == t_done && !own_dm});
                    chk(g, "dm_done",  {31'd0, bus.dm_done}, {31'd0, c == t_done && own_dm});
                    chk(g, "mem_en",   {31'd0, bus.mem_en},  {31'd0, c == t_gnt});
                    chk(g, "mem_we",   {31'd0, bus.mem_we},  {31'd0, c == t_gnt && own_we});
                    chk(g, "busy",     {31'd0, bus.busy},    {31'd0, c >= t_gnt && c <= t_done});
                    chk(g, "if_rdata", bus.if_rdata, ex_if);
                    chk(g, "dm_rdata", bus.dm_rdata, ex_dm);
                    if (c == t_gnt) begin
                        chk(g, "mem_addr",  bus.mem_addr,  own_addr);
                        chk(g, "mem_wdata", bus.mem_wdata, own_wdata);
                    end
                    if (prev_rst) begin
                        chk(g, "rst_addr",  bus.mem_addr,  32'd0);
                        chk(g, "rst_wdata", bus.mem_wdata, 32'd0);
                    end
                end

                // Stimulus for cycle c
                r = (c < 3) || ($urandom_range(0, 299) == 0);
                if (!forced && c > 1500 && c == t_gnt + 1) begin
                    r      = 1'b1;
                    forced = 1'b1;
                end

                if (bus.if_req && c == if_gc + 1) begin
                    bus.if_req = ($urandom_range(0, 1) == 0);
                end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                    bus.if_req  = 1'b1;
                    bus.if_addr = $urandom;
                end

                if (bus.dm_req && c == dm_gc + 1) begin
                    bus.dm_req = ($urandom_range(0, 1) == 0);
                end else if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
                    bus.dm_req   = 1'b1;
                    bus.dm_we    = 1'($urandom_range(0, 1));
                    bus.dm_addr  = $urandom;
                    bus.dm_wdata = $urandom;
                end

                bus.mem_rdata = $urandom;
                if (c == t_gnt + LAT) cap = bus.mem_rdata;
                rst = r;

                if (!r && c >= arb_ok && (bus.if_req || bus.dm_req)) begin
                    if (PRIO != 0)                   pd = bus.dm_req;
                    else if (bus.dm_req && bus.if_req) pd = !last_dm;
                    else                             pd = bus.dm_req;
                    own_dm    = pd;
                    own_we    = pd && bus.dm_we;
                    own_addr  = pd ? bus.dm_addr : bus.if_addr;
                    own_wdata = pd ? bus.dm_wdata : 32'd0;
                    t_gnt     = c + 1;
                    t_done    = c + 2 + LAT;
                    arb_ok    = t_done;
                    last_dm   = pd;
                    if (pd) dm_gc = c + 1;
                    else    if_gc = c + 1;
                end

                if (r) begin
                    t_gnt   = -100;
                    t_done  = -100;
                    ex_if   = '0;
                    ex_dm   = '0;
                    last_dm = 1'b0;
                    arb_ok  = c + 1;
                end
                prev_rst = r;
            end
            fin = 1'b1;
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        wait (g_cfg[0].fin && g_cfg[1].fin);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
